// File: rtl/emulib_axi_latency_model_pkg.sv
// Shared helpers for the emulib AXI latency model: latency clamping, wrap-safe
// due test and the AXI burst-length width.
package emulib_axi_latency_model_pkg;

    localparam int unsigned AXI_LEN_WIDTH = 8;

    // Zero latency is promoted to one cycle so every response is registered.
    function automatic logic [31:0] leff(input logic [31:0] cfg);
        return (cfg == '0) ? 32'd1 : cfg;
    endfunction

    // Due when (now - due) is non-negative as a ts_w-bit signed value.
    function automatic logic ts_is_due(input logic [63:0] now_v,
                                       input logic [63:0] due_v,
                                       input int unsigned ts_w);
        logic [63:0] diff;
        logic [63:0] msb;
        diff = now_v - due_v;
        msb  = diff >> (ts_w - 32'd1);
        return ~msb[0];
    endfunction

endpackage

// File: rtl/emulib_ticket_fifo.sv
// Synchronous circular FIFO with registered head, occupancy count and
// empty/full flags; pushes when full and pops when empty are ignored.
module emulib_ticket_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == CW'(DEPTH));
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
        count   = cnt;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/emulib_axi_latency_model.sv
// AXI timing model: observes AR/AW/W handshakes and answers with R bursts and
// B responses after programmable latencies, multiple transactions in flight.
module emulib_axi_latency_model
    import emulib_axi_latency_model_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MAX_R_INFLIGHT = 4,
    parameter int unsigned MAX_W_INFLIGHT = 4,
    parameter int unsigned LAT_WIDTH      = 8,
    parameter int unsigned TS_WIDTH       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [LAT_WIDTH-1:0]                  cfg_rlat,
    input  logic [LAT_WIDTH-1:0]                  cfg_wlat,
    input  logic                                  arvalid,
    output logic                                  arready,
    input  logic [ID_WIDTH-1:0]                   arid,
    input  logic [7:0]                            arlen,
    input  logic                                  awvalid,
    output logic                                  awready,
    input  logic [ID_WIDTH-1:0]                   awid,
    input  logic                                  wvalid,
    output logic                                  wready,
    input  logic                                  wlast,
    output logic                                  rvalid,
    input  logic                                  rready,
    output logic [ID_WIDTH-1:0]                   rid,
    output logic                                  rlast,
    output logic                                  bvalid,
    input  logic                                  bready,
    output logic [ID_WIDTH-1:0]                   bid,
    output logic [$clog2(MAX_R_INFLIGHT+1)-1:0]   r_inflight,
    output logic [$clog2(MAX_W_INFLIGHT+1)-1:0]   w_inflight
);

    localparam int unsigned RCW = $clog2(MAX_R_INFLIGHT + 1);
    localparam int unsigned WCW = $clog2(MAX_W_INFLIGHT + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]      id;
        logic [AXI_LEN_WIDTH-1:0] len;
        logic [TS_WIDTH-1:0]      due;
    } rd_entry_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [TS_WIDTH-1:0] due;
    } b_entry_t;

    logic                     live_q;
    logic [TS_WIDTH-1:0]      now_q;
    logic [AXI_LEN_WIDTH-1:0] beat_q;
    logic [RCW-1:0]           r_cnt_q;
    logic [WCW-1:0]           w_cnt_q;
    logic                     r_due_q;
    logic                     b_due_q;

    rd_entry_t                rq_in;
    rd_entry_t                rq_head;
    logic                     rq_empty;
    logic                     rq_full;
    logic [RCW-1:0]           rq_count;

    logic [ID_WIDTH-1:0]      aw_head;
    logic                     aw_empty;
    logic                     aw_full;
    logic [WCW-1:0]           aw_count;

    logic                     wl_head;
    logic                     wl_empty;
    logic                     wl_full;
    logic [WCW-1:0]           wl_count;

    b_entry_t                 bq_in;
    b_entry_t                 bq_head;
    logic                     bq_empty;
    logic                     bq_full;
    logic [WCW-1:0]           bq_count;

    logic                     ar_hs;
    logic                     aw_hs;
    logic                     wl_hs;
    logic                     r_hs;
    logic                     r_pop;
    logic                     b_hs;
    logic                     pair;
    logic                     r_head_due;
    logic                     b_head_due;
    logic                     unused_fifo_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            now_q  <= '0;
        end else begin
            live_q <= 1'b1;
            now_q  <= now_q + TS_WIDTH'(1);
        end
    end

    always_comb begin
        arready    = live_q && (r_cnt_q < RCW'(MAX_R_INFLIGHT));
        ar_hs      = arvalid && arready;
        rq_in.id   = arid;
        rq_in.len  = arlen;
        rq_in.due  = now_q + TS_WIDTH'(leff(32'(cfg_rlat)));

        // The sticky flag keeps a granted head valid even if (now - due) later wraps.
        r_head_due = ts_is_due(64'(now_q), 64'(rq_head.due), TS_WIDTH);
        rvalid     = !rq_empty && (r_due_q || r_head_due);
        rid        = rvalid ? rq_head.id : '0;
        rlast      = rvalid && (beat_q == rq_head.len);
        r_hs       = rvalid && rready;
        r_pop      = r_hs && rlast;
        r_inflight = r_cnt_q;
    end

    emulib_ticket_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (MAX_R_INFLIGHT)
    ) u_read_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data (rq_in),
        .pop       (r_pop),
        .head      (rq_head),
        .count     (rq_count),
        .empty     (rq_empty),
        .full      (rq_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            r_due_q <= 1'b0;
            r_cnt_q <= '0;
        end else begin
            if (r_hs) begin
                beat_q <= r_pop ? '0 : beat_q + AXI_LEN_WIDTH'(1);
            end
            r_due_q <= r_pop ? 1'b0 : rvalid;
            if (ar_hs && !r_pop) begin
                r_cnt_q <= r_cnt_q + RCW'(1);
            end else if (!ar_hs && r_pop) begin
                r_cnt_q <= r_cnt_q - RCW'(1);
            end
        end
    end

    always_comb begin
        awready    = live_q && (w_cnt_q < WCW'(MAX_W_INFLIGHT));
        wready     = live_q && !wl_full;
        aw_hs      = awvalid && awready;
        wl_hs      = wvalid && wready && wlast;
        pair       = !aw_empty && !wl_empty;
        bq_in.id   = aw_head;
        bq_in.due  = now_q + TS_WIDTH'(leff(32'(cfg_wlat)));

        b_head_due = ts_is_due(64'(now_q), 64'(bq_head.due), TS_WIDTH);
        bvalid     = !bq_empty && (b_due_q || b_head_due);
        bid        = bvalid ? bq_head.id : '0;
        b_hs       = bvalid && bready;
        w_inflight = w_cnt_q;
    end

    emulib_ticket_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_W_INFLIGHT)
    ) u_aw_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aw_hs),
        .push_data (awid),
        .pop       (pair),
        .head      (aw_head),
        .count     (aw_count),
        .empty     (aw_empty),
        .full      (aw_full)
    );

    emulib_ticket_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_W_INFLIGHT)
    ) u_wlast_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wl_hs),
        .push_data (1'b1),
        .pop       (pair),
        .head      (wl_head),
        .count     (wl_count),
        .empty     (wl_empty),
        .full      (wl_full)
    );

    // Sized like the AW FIFO: awready gating bounds AW FIFO plus B queue occupancy.
    emulib_ticket_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (MAX_W_INFLIGHT)
    ) u_b_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pair),
        .push_data (bq_in),
        .pop       (b_hs),
        .head      (bq_head),
        .count     (bq_count),
        .empty     (bq_empty),
        .full      (bq_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_due_q <= 1'b0;
            w_cnt_q <= '0;
        end else begin
            b_due_q <= b_hs ? 1'b0 : bvalid;
            if (aw_hs && !b_hs) begin
                w_cnt_q <= w_cnt_q + WCW'(1);
            end else if (!aw_hs && b_hs) begin
                w_cnt_q <= w_cnt_q - WCW'(1);
            end
        end
    end

    assign unused_fifo_status = &{1'b0, rq_full, rq_count, aw_full, aw_count,
                                  wl_head, wl_count, bq_full, bq_count};

endmodule

// File: tb/tb_emulib_axi_latency_model.sv
// Directed bench for emulib_axi_latency_model: expected R/B responses are
// queued at issue time and checked by an independent monitor.
module tb_emulib_axi_latency_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_rlat;
    logic [2:0] cfg_wlat;
    logic       arvalid;
    logic       arready;
    logic [3:0] arid;
    logic [7:0] arlen;
    logic       awvalid;
    logic       awready;
    logic [3:0] awid;
    logic       wvalid;
    logic       wready;
    logic       wlast;
    logic       rvalid;
    logic       rready;
    logic [3:0] rid;
    logic       rlast;
    logic       bvalid;
    logic       bready;
    logic [3:0] bid;
    logic [1:0] r_inflight;
    logic [2:0] w_inflight;

    emulib_axi_latency_model #(
        .ID_WIDTH       (4),
        .MAX_R_INFLIGHT (2),
        .MAX_W_INFLIGHT (4),
        .LAT_WIDTH      (3),
        .TS_WIDTH       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_rlat   (cfg_rlat),
        .cfg_wlat   (cfg_wlat),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .arlen      (arlen),
        .awvalid    (awvalid),
        .awready    (awready),
        .awid       (awid),
        .wvalid     (wvalid),
        .wready     (wready),
        .wlast      (wlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rlast      (rlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (bid),
        .r_inflight (r_inflight),
        .w_inflight (w_inflight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference timestamp used only to place an AR at a chosen counter value.
    logic [3:0] tb_now;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_now <= 4'd0;
        else        tb_now <= tb_now + 4'd1;
    end

    typedef struct {
        int         cyc;
        logic [3:0] id;
        logic       last;
    } exp_t;

    exp_t r_exp[$];
    exp_t b_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (rvalid && rready) begin
                n_cmp++;
                if (r_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL r_unexpected: rid=%0d rlast=%0b at cycle %0d, nothing expected", rid, rlast, cyc);
                end else begin
                    e = r_exp.pop_front();
                    if ((e.cyc >= 0 && e.cyc != cyc) || rid !== e.id || rlast !== e.last) begin
                        n_err++;
                        $display("FAIL r_beat: got cycle=%0d id=%0d last=%0b expected cycle=%0d id=%0d last=%0b",
                                 cyc, rid, rlast, e.cyc, e.id, e.last);
                    end
                end
            end
            if (bvalid && bready) begin
                n_cmp++;
                if (b_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL b_unexpected: bid=%0d at cycle %0d, nothing expected", bid, cyc);
                end else begin
                    e = b_exp.pop_front();
                    if ((e.cyc >= 0 && e.cyc != cyc) || bid !== e.id) begin
                        n_err++;
                        $display("FAIL b_resp: got cycle=%0d id=%0d expected cycle=%0d id=%0d",
                                 cyc, bid, e.cyc, e.id);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic to_cycle_start(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(r_exp.size() + b_exp.size()), 32'd0);
    endtask

    task automatic ar_issue(input logic [3:0] id, input logic [7:0] len, input logic [2:0] lat,
                            input bit track, output int t);
        int lf;
        int n = 0;
        lf = (lat == 3'd0) ? 1 : int'(lat);
        @(posedge clk);
        #1;
        cfg_rlat = lat;
        arid     = id;
        arlen    = len;
        arvalid  = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!arready) begin
            chk("ar_accept_timeout", 32'(arready), 32'd1);
            t = -1;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (track && t >= 0) begin
            for (int k = 0; k <= int'(len); k++) begin
                r_exp.push_back('{t + lf + k, id, (k == int'(len))});
            end
        end
    endtask

    task automatic aw_issue(input logic [3:0] id, input logic [2:0] lat, output int t);
        int n = 0;
        @(posedge clk);
        #1;
        cfg_wlat = lat;
        awid     = id;
        awvalid  = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!awready) chk("aw_accept_timeout", 32'(awready), 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic last, output int t);
        int n = 0;
        @(posedge clk);
        #1;
        wlast  = last;
        wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!wready) chk("w_accept_timeout", 32'(wready), 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t0, s, ta, tw, a;
        rst_n    = 1'b0;
        cfg_rlat = 3'd0;
        cfg_wlat = 3'd0;
        arvalid  = 1'b0;
        arid     = 4'd0;
        arlen    = 8'd0;
        awvalid  = 1'b0;
        awid     = 4'd0;
        wvalid   = 1'b0;
        wlast    = 1'b0;
        rready   = 1'b0;
        bready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rid_rlast_bid", 32'({rid, rlast, bid}), 32'd0);
        chk("rst_counts", 32'({r_inflight, w_inflight}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_live", 32'({arready, awready, wready}), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_live", 32'({arready, awready, wready}), 32'b111);

        // Four-beat read, latency 5
        rready = 1'b1;
        ar_issue(4'd3, 8'd3, 3'd5, 1'b1, t);
        wait_cyc(t + 8);
        chk("r_inflight_last_beat", 32'(r_inflight), 32'd1);
        wait_cyc(t + 9);
        chk("r_inflight_after_burst", 32'(r_inflight), 32'd0);
        drain();

        // Latency 0 and 1 both respond one cycle after the handshake
        ar_issue(4'd1, 8'd0, 3'd0, 1'b1, t);
        drain();
        ar_issue(4'd2, 8'd0, 3'd1, 1'b1, t);
        drain();

        // AR at now=12 with latency 7: due wraps to 3
        for (int i = 0; i < 40 && tb_now != 4'd11; i++) begin
            @(posedge clk);
            #1;
        end
        ar_issue(4'd10, 8'd0, 3'd7, 1'b1, t);
        drain();

        // Outstanding limit of 2 with rready held low
        rready = 1'b0;
        @(posedge clk);
        #1;
        cfg_rlat = 3'd2;
        arvalid  = 1'b1;
        arid     = 4'd4;
        arlen    = 8'd1;
        @(negedge clk);
        t0 = cyc;
        chk("ar_bp_first", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
        arid  = 4'd5;
        arlen = 8'd0;
        @(negedge clk);
        chk("ar_bp_second", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
        arid = 4'd6;
        @(negedge clk);
        chk("ar_bp_full", 32'(arready), 32'd0);
        chk("r_inflight_full", 32'(r_inflight), 32'd2);
        for (int k = 2; k <= 4; k++) begin
            wait_cyc(t0 + k);
            chk("r_hold_stable", 32'({rvalid, rid, rlast, arready}), 32'({1'b1, 4'd4, 1'b0, 1'b0}));
        end
        s = t0 + 5;
        r_exp.push_back('{s,     4'd4, 1'b0});
        r_exp.push_back('{s + 1, 4'd4, 1'b1});
        r_exp.push_back('{s + 2, 4'd5, 1'b1});
        r_exp.push_back('{s + 4, 4'd6, 1'b1});
        to_cycle_start(s);
        rready = 1'b1;
        wait_cyc(s + 1);
        chk("ar_still_blocked", 32'(arready), 32'd0);
        wait_cyc(s + 2);
        chk("ar_reopened", 32'(arready), 32'd1);
        chk("r_inflight_after_pop", 32'(r_inflight), 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        drain();

        // W before AW, latency 4, B backpressured for 3 cycles
        bready = 1'b0;
        w_beat(1'b0, tw);
        w_beat(1'b1, tw);
        wait_cyc(tw + 4);
        aw_issue(4'd5, 3'd4, ta);
        a = ta;
        b_exp.push_back('{a + 8, 4'd5, 1'b0});
        wait_cyc(a + 1);
        chk("w_inflight_after_aw", 32'(w_inflight), 32'd1);
        wait_cyc(a + 4);
        chk("b_not_yet_due", 32'(bvalid), 32'd0);
        for (int k = 5; k <= 7; k++) begin
            wait_cyc(a + k);
            chk("b_hold_stable", 32'({bvalid, bid}), 32'({1'b1, 4'd5}));
        end
        to_cycle_start(a + 8);
        bready = 1'b1;
        wait_cyc(a + 9);
        chk("w_inflight_after_b", 32'(w_inflight), 32'd0);
        drain();

        // AW before W, latency 0
        aw_issue(4'd9, 3'd0, ta);
        w_beat(1'b1, tw);
        b_exp.push_back('{((ta > tw) ? ta : tw) + 2, 4'd9, 1'b0});
        drain();

        // Reset with two reads and one write outstanding
        rready = 1'b0;
        bready = 1'b0;
        ar_issue(4'd1, 8'd0, 3'd1, 1'b0, t);
        ar_issue(4'd2, 8'd0, 3'd1, 1'b0, t);
        w_beat(1'b1, tw);
        aw_issue(4'd7, 3'd7, ta);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_counts", 32'({r_inflight, w_inflight}), 32'({2'd2, 3'd1}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
        chk("mid_rst_counts", 32'({r_inflight, w_inflight}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_not_live", 32'({arready, awready, wready}), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_live", 32'({arready, awready, wready}), 32'b111);
        chk("post_rst_counts", 32'({r_inflight, w_inflight}), 32'd0);
        rready = 1'b1;
        bready = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_stale_valid", 32'({rvalid, bvalid}), 32'd0);
        chk("final_queues", 32'(r_exp.size() + b_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
